// File: rtl/dut_sched_pkg.sv
// dut_sched_pkg: shared types and default timing for the pipeline scheduler.
//   LATENCY      - clock edges from issue to valid X/Y/Z
//   FLUSH_CYCLES - zero-input cycles needed to clear the shift stages
//   state_e      - scheduler FSM states
//   tag_t        - per-issue tracking tag {valid, id}
package dut_sched_pkg;
    localparam int LATENCY = 5;
    localparam int FLUSH_CYCLES = 3;
    typedef enum logic [1:0] {FLUSH, RUN, DRAIN} state_e;
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - grants allowed this cycle
//   req_i         - per-requester valid
//   issue_i       - a grant was taken; updates the round-robin pointer
//   gnt_o         - one-hot grant, already qualified by req_i and en_i
//   gnt_id_o      - index of the preferred requester
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       issue_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);
    logic rr_last_q, rr_last_d;
    // req1 wins when alone, or when both ask and req1 was not the last winner
    always_comb begin
        gnt_id_o  = req_i[1] & (~req_i[0] | ~rr_last_q);
        gnt_o     = en_i ? {req_i[1] & gnt_id_o, req_i[0] & ~gnt_id_o} : 2'b00;
        rr_last_d = issue_i ? gnt_id_o : rr_last_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_last_q <= 1'b1;
        else         rr_last_q <= rr_last_d;
    end
endmodule

// File: rtl/dut_pipe_sched.sv
// dut_pipe_sched: flushes, arbitrates and tracks issues into a shared A/B -> X/Y/Z pipeline.
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   reqN_valid_i/_a_i/_b_i         - requester N vector and operands
//   reqN_ready_o                   - requester N vector accepted this cycle
//   flush_req_i                    - level request to drain and re-flush
//   dut_a_o, dut_b_o               - operands driven into the pipeline
//   dut_x_i, dut_y_i, dut_z_i      - pipeline outputs
//   rsp_valid_o, rsp_id_o          - response valid and owning requester
//   rsp_x_o, rsp_y_o, rsp_z_o      - response data
//   inflight_o                     - issued, unreturned vectors
//   busy_o                         - scheduler not in RUN
module dut_pipe_sched
    import dut_sched_pkg::*;
#(
    parameter int LATENCY      = dut_sched_pkg::LATENCY,
    parameter int FLUSH_CYCLES = dut_sched_pkg::FLUSH_CYCLES,
    parameter int CW           = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req0_valid_i,
    input  logic          req0_a_i,
    input  logic          req0_b_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic          req1_a_i,
    input  logic          req1_b_i,
    output logic          req1_ready_o,
    input  logic          flush_req_i,
    output logic          dut_a_o,
    output logic          dut_b_o,
    input  logic          dut_x_i,
    input  logic          dut_y_i,
    input  logic          dut_z_i,
    output logic          rsp_valid_o,
    output logic          rsp_id_o,
    output logic          rsp_x_o,
    output logic          rsp_y_o,
    output logic          rsp_z_o,
    output logic [CW-1:0] inflight_o,
    output logic          busy_o
);
    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, inflight_q, inflight_d;
    tag_t [LATENCY-1:0]      tag_q, tag_d;
    logic [1:0]              gnt;
    logic                    gnt_id, issue, en;

    // no grant in the cycle a flush request is seen
    assign en = (state_q == RUN) && !flush_req_i;

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en),
        .req_i    ({req1_valid_i, req0_valid_i}),
        .issue_i  (issue),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FLUSH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:   state_d = flush_req_i ? DRAIN : RUN;
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    // gnt is already qualified by valid, so a grant is an issue
    always_comb begin
        issue        = |gnt;
        req0_ready_o = gnt[0];
        req1_ready_o = gnt[1];
        dut_a_o      = (gnt[0] & req0_a_i) | (gnt[1] & req1_a_i);
        dut_b_o      = (gnt[0] & req0_b_i) | (gnt[1] & req1_b_i);
        tag_d        = {tag_q[LATENCY-2:0], tag_t'{valid: issue, id: gnt_id}};
        rsp_valid_o  = tag_q[LATENCY-1].valid;
        rsp_id_o     = tag_q[LATENCY-1].id;
        inflight_d   = inflight_q + CW'(issue) - CW'(rsp_valid_o);
    end

    assign rsp_x_o    = dut_x_i;
    assign rsp_y_o    = dut_y_i;
    assign rsp_z_o    = dut_z_i;
    assign inflight_o = inflight_q;
    assign busy_o     = state_q != RUN;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FLUSH;
            cnt_q      <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_dut_pipe_sched.sv
// tb_dut_pipe_sched: directed self-checking bench for dut_pipe_sched with a behavioural pipeline.
module tb_dut_pipe_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r0v = 1'b0, r0a = 1'b0, r0b = 1'b0;
    logic r1v = 1'b0, r1a = 1'b0, r1b = 1'b0;
    logic flush = 1'b0;
    logic r0rdy, r1rdy, da, db, dx, dy, dz;
    logic rsp_v, rsp_id, rx, ry, rz, busy;
    logic [2:0] inflight;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // pipeline: two reset flop stages (AND in the second), then three non-resettable shift stages
    logic p1a, p1b, p2x, p2y, p2z;
    logic [2:0] sx, sy, sz;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {p1a, p1b, p2x, p2y, p2z} <= '0;
        else begin
            p1a <= da;
            p1b <= db;
            p2x <= p1a;
            p2y <= p1a & p1b;
            p2z <= p1b;
        end
    end
    always_ff @(posedge clk) begin
        sx <= {sx[1:0], p2x};
        sy <= {sy[1:0], p2y};
        sz <= {sz[1:0], p2z};
    end
    assign dx = sx[2];
    assign dy = sy[2];
    assign dz = sz[2];

    dut_pipe_sched dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(r0v), .req0_a_i(r0a), .req0_b_i(r0b), .req0_ready_o(r0rdy),
        .req1_valid_i(r1v), .req1_a_i(r1a), .req1_b_i(r1b), .req1_ready_o(r1rdy),
        .flush_req_i(flush), .dut_a_o(da), .dut_b_o(db),
        .dut_x_i(dx), .dut_y_i(dy), .dut_z_i(dz),
        .rsp_valid_o(rsp_v), .rsp_id_o(rsp_id), .rsp_x_o(rx), .rsp_y_o(ry), .rsp_z_o(rz),
        .inflight_o(inflight), .busy_o(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r0v = 1; r0a = 1; r0b = 1; r1v = 1; r1a = 0; r1b = 1;
        @(negedge clk);
        checks++;
        if ({r0rdy, r1rdy, rsp_v, busy, da, db, inflight} !== 9'b000100_000) begin
            errs++;
            $display("FAIL reset_state: got %b exp 000100000", {r0rdy, r1rdy, rsp_v, busy, da, db, inflight});
        end
        step();
        rst_n = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({r0rdy, r1rdy, da, db, busy} !== 5'b00001) begin
                errs++;
                $display("FAIL flush_cycle%0d: got %b exp 00001", c, {r0rdy, r1rdy, da, db, busy});
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({r0rdy, r1rdy, da, db, busy} !== 5'b10110) begin
            errs++;
            $display("FAIL first_grant: got %b exp 10110", {r0rdy, r1rdy, da, db, busy});
        end
        step();
    endtask

    task automatic test_single();
        r0v = 0; r1v = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_v !== (k == 5)) begin
                errs++;
                $display("FAIL single_rsp_valid k=%0d: got %b exp %b", k, rsp_v, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if ({rsp_id, rx, ry, rz} !== 4'b0111) begin
                    errs++;
                    $display("FAIL single_rsp_data: got %b exp 0111", {rsp_id, rx, ry, rz});
                end
            end
            if (k == 6) begin
                checks++;
                if (inflight !== 3'd0) begin
                    errs++;
                    $display("FAIL single_inflight: got %0d exp 0", inflight);
                end
            end
            step();
        end
    endtask

    task automatic test_alternate();
        logic g1, r;
        r0v = 1; r0a = 1; r0b = 0; r1v = 1; r1a = 0; r1b = 1;
        for (int i = 0; i < 10; i++) begin
            g1 = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if ({r0rdy, r1rdy, da, db} !== {~g1, g1, ~g1, g1}) begin
                errs++;
                $display("FAIL alt_grant i=%0d: got %b exp %b", i, {r0rdy, r1rdy, da, db}, {~g1, g1, ~g1, g1});
            end
            checks++;
            if (inflight !== 3'(i < 5 ? i : 5)) begin
                errs++;
                $display("FAIL alt_inflight i=%0d: got %0d exp %0d", i, inflight, (i < 5 ? i : 5));
            end
            if (i >= 5) begin
                r = ((i - 5) % 2 == 0);
                checks++;
                if ({rsp_v, rsp_id, rx, ry, rz} !== {1'b1, r, ~r, 1'b0, r}) begin
                    errs++;
                    $display("FAIL alt_rsp i=%0d: got %b exp %b", i, {rsp_v, rsp_id, rx, ry, rz}, {1'b1, r, ~r, 1'b0, r});
                end
            end else begin
                checks++;
                if (rsp_v !== 1'b0) begin
                    errs++;
                    $display("FAIL alt_early_rsp i=%0d: got %b exp 0", i, rsp_v);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        r0v = 0; r1v = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            @(negedge clk);
            if (inflight == 3'd0) break;
        end
        checks++;
        if (inflight !== 3'd0) begin
            errs++;
            $display("FAIL drain_timeout: inflight got %0d exp 0", inflight);
        end
        step();
        r1v = 1; r1a = 1; r1b = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({r0rdy, r1rdy, da, db} !== 4'b0111) begin
                errs++;
                $display("FAIL b2b_grant c=%0d: got %b exp 0111", c, {r0rdy, r1rdy, da, db});
            end
            step();
        end
    endtask

    task automatic test_flush();
        logic ev;
        r1v = 0; r0v = 1; r0a = 1; r0b = 1; flush = 1;
        @(negedge clk);
        checks++;
        if ({r0rdy, r1rdy, da, db, inflight} !== 7'b0000_011) begin
            errs++;
            $display("FAIL flush_seen: got %b exp 0000011", {r0rdy, r1rdy, da, db, inflight});
        end
        step();
        flush = 0;
        for (int c = 4; c <= 11; c++) begin
            ev = (c >= 5 && c <= 7);
            @(negedge clk);
            checks++;
            if ({r0rdy, da, db, busy, rsp_v} !== {4'b0001, ev}) begin
                errs++;
                $display("FAIL drain c=%0d: got %b exp %b", c, {r0rdy, da, db, busy, rsp_v}, {4'b0001, ev});
            end
            if (ev) begin
                checks++;
                if ({rsp_id, rx, ry, rz} !== 4'b1111) begin
                    errs++;
                    $display("FAIL drain_rsp c=%0d: got %b exp 1111", c, {rsp_id, rx, ry, rz});
                end
            end
            if (c == 8) begin
                checks++;
                if (inflight !== 3'd0) begin
                    errs++;
                    $display("FAIL drain_inflight: got %0d exp 0", inflight);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({r0rdy, da, db, busy, inflight} !== 7'b1110_000) begin
            errs++;
            $display("FAIL run_resume: got %b exp 1110000", {r0rdy, da, db, busy, inflight});
        end
        step();
    endtask

    task automatic test_reset_mid();
        r0v = 0;
        @(negedge clk);
        checks++;
        if (inflight !== 3'd1) begin
            errs++;
            $display("FAIL mid_inflight: got %0d exp 1", inflight);
        end
        step();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({rsp_v, busy, r0rdy, inflight} !== 6'b010_000) begin
            errs++;
            $display("FAIL mid_reset_state: got %b exp 010000", {rsp_v, busy, r0rdy, inflight});
        end
        step();
        rst_n = 1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            checks++;
            if ({rsp_v, busy} !== {1'b0, (j <= 3)}) begin
                errs++;
                $display("FAIL post_reset j=%0d: got %b exp %b", j, {rsp_v, busy}, {1'b0, (j <= 3)});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dut_pipe_sched.md
Name: dut_pipe_sched

Overview:
- Scheduler that shares the 1-bit A/B → X/Y/Z pipeline (two reset flops, AND stage, three-deep shift registers) between two requesters.
- Flushes the pipeline's non-resettable shift stages after reset, then arbitrates round-robin between the requesters, one issue per cycle.
- Tracks each issue with a latency-matched tag pipe and returns the pipeline outputs to the correct requester exactly LATENCY cycles later.
- Sits between the two test-vector sources and the pipeline instance.

Parameters:
- LATENCY, 5: clock edges from issue to valid X/Y/Z (2 flop stages plus 3 shift stages).
- FLUSH_CYCLES, 3: cycles of zero input needed to clear the shift stages.
- CW, 3: width of the flush/drain counter; must hold max(LATENCY, FLUSH_CYCLES).

Ports:
- clk input 1: single clock, rising edge.
- rst input 1: asynchronous, active-low reset. Also wired to the pipeline's flop resets.
- req0_valid input 1: requester 0 has a vector.
- req0_a input 1: requester 0 A operand.
- req0_b input 1: requester 0 B operand.
- req0_ready output 1: requester 0 vector accepted this cycle.
- req1_valid / req1_a / req1_b inputs 1 each: requester 1, same meaning as requester 0.
- req1_ready output 1: requester 1 vector accepted this cycle.
- flush_req input 1: level request to drain and re-flush the pipeline.
- dut_a output 1: A input to the pipeline.
- dut_b output 1: B input to the pipeline.
- dut_x / dut_y / dut_z inputs 1 each: pipeline outputs.
- rsp_valid output 1: response valid this cycle.
- rsp_id output 1: requester the response belongs to.
- rsp_x / rsp_y / rsp_z outputs 1 each: response data, pass-through of dut_x/y/z.
- inflight output CW: number of issued, unreturned vectors.
- busy output 1: high whenever state ≠ RUN.

Behaviour:
- On rst low, immediately (asynchronously):
  - state = FLUSH, counter = 0, tag pipe cleared.
  - rr_last = 1, so req0 wins the first contest.
  - All ready outputs = 0; rsp_valid = 0; inflight = 0; busy = 1.
  - dut_a = 0, dut_b = 0.
- FSM:
  - FLUSH: drive dut_a = dut_b = 0, no grants. Counter increments each cycle. After FLUSH_CYCLES cycles with counter = FLUSH_CYCLES-1, go to RUN.
  - RUN: arbitrate.
    - flush_req sampled high → DRAIN next cycle. No grant in the cycle flush_req is seen high.
  - DRAIN: no grants, dut_a/b = 0. When inflight = 0, go to FLUSH with counter cleared.
- Arbitration (RUN only):
  - Only one valid → grant it.
  - Both valid → grant the requester ≠ rr_last.
  - reqN_ready = (state == RUN) && !flush_req && grant == N. Ready may depend on valid; valid must not depend on ready.
  - Issue = valid && ready. dut_a/b = granted operands combinationally; the pipeline samples them at the next edge.
  - rr_last updates to the granted id only on an issue.
  - Non-issue cycles drive dut_a = dut_b = 0.
- Tag pipe: LATENCY-deep shift of {valid, id}, advancing every cycle.
  - Stage 0 is loaded with {issue, grant id}.
  - rsp_valid = last stage valid; rsp_id = last stage id.
  - A vector issued at edge t yields rsp_valid high in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after the issue cycle.
  - Responses cannot be back-pressured.
- inflight: +1 on issue, −1 on rsp_valid, unchanged when both happen in the same cycle. Never exceeds LATENCY.
- rsp_x/y/z are meaningful only when rsp_valid = 1; otherwise they reflect flush zeros.
- Reset asserted mid-operation discards all in-flight tags; no stale rsp_valid after reset release.

Decomposition:
- Package dut_sched_pkg holds:
  - state enum {FLUSH, RUN, DRAIN};
  - localparam defaults LATENCY = 5, FLUSH_CYCLES = 3;
  - the tag struct {valid, id}.
- One sub-module, rr_arb2: 2-way round-robin arbiter with rr_last register and an issue input. The tag pipe stays inline.

Test Plan:
- Reset release, both valid = 1 → ready = 0 and dut_a/b = 0 for exactly 3 cycles, busy = 1; first grant to req0 in cycle 4.
- req0 issues a=1, b=1 once → exactly 5 cycles later rsp_valid = 1, rsp_id = 0, X = 1, Y = 1, Z = 1; no other rsp_valid.
- Both requesters continuously valid (req0 a=1 b=0, req1 a=0 b=1) → grants alternate 0, 1, 0, 1; responses alternate id 0 (X=1 Y=0 Z=0) / id 1 (X=0 Y=0 Z=1); inflight saturates at 5.
- flush_req pulsed with 3 in flight → no new grants; 3 responses return; then 3 flush cycles; RUN resumes with inflight = 0.
- rst driven low 2 cycles after an issue → rsp_valid never asserts for it; state restarts in FLUSH.
- Only req1 valid after a req1 grant → req1 granted again on consecutive cycles; no idle bubble.
